// File: rtl/simplerisc_pkg.sv
// Shared types and constants for the operand-fetch stage: FSM states,
// shift codes, ALU op codes and the register-file geometry.
package simplerisc_pkg;

  localparam int NREGS  = 8;
  localparam int IDX_W  = $clog2(NREGS);
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RD_A  = 2'b01,
    S_RD_B  = 2'b10,
    S_VALID = 2'b11
  } state_t;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  function automatic logic [DATA_W-1:0] sx_imm5(input logic [4:0] imm);
    return {{(DATA_W-5){imm[4]}}, imm};
  endfunction

endpackage

// File: rtl/shifter.sv
// Combinational one-bit B-operand shifter: none, LSL1, LSR1 (zero fill),
// ASR1 (sign fill). Width stays 16 bits; bits shifted out are lost.
module shifter
  import simplerisc_pkg::*;
(
  input  logic [DATA_W-1:0] din_i,
  input  logic [1:0]        code_i,
  output logic [DATA_W-1:0] dout_o
);

  always_comb begin
    dout_o = din_i;
    case (code_i)
      SH_LSL1: dout_o = {din_i[DATA_W-2:0], 1'b0};
      SH_LSR1: dout_o = {1'b0, din_i[DATA_W-1:1]};
      SH_ASR1: dout_o = {din_i[DATA_W-1], din_i[DATA_W-1:1]};
      default: dout_o = din_i;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: 8x16 register file with one read port, reads A then B
// over two cycles and holds ain/bin/aluop under valid until ack.
// Optional OPERAND_FETCH_BYPASS_EN forwards a same-cycle write to the read.
//
// Handshake: valid stays high with ain/bin/aluop frozen until ack is sampled
// high; ready is high only in IDLE, and start is accepted only while ready=1.
module operand_fetch
  import simplerisc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  rn,
  input  logic [IDX_W-1:0]  rm,
  input  logic [1:0]        shift,
  input  logic              asel,
  input  logic              bsel,
  input  logic [4:0]        imm5,
  input  logic [1:0]        aluop_in,
  input  logic              ack,
  input  logic              wb_en,
  input  logic [IDX_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] ain,
  output logic [DATA_W-1:0] bin,
  output logic [1:0]        aluop,
  output logic              valid,
  output logic              ready
);

  state_t             state_q;
  logic [IDX_W-1:0]   rn_q, rm_q;
  logic [1:0]         shift_q;
  logic               asel_q, bsel_q;
  logic [4:0]         imm5_q;
  logic [1:0]         aluop_q;
  logic [DATA_W-1:0]  ain_q, bin_q;
  logic               valid_q, ready_q;
  logic [DATA_W-1:0]  regs_q [NREGS];

  logic [IDX_W-1:0]   rd_idx;
  logic [DATA_W-1:0]  rd_data;
  logic [DATA_W-1:0]  rd_shifted;

  // The single read port serves rn in RD_A and rm otherwise.
  assign rd_idx = (state_q == S_RD_A) ? rn_q : rm_q;

`ifdef OPERAND_FETCH_BYPASS_EN
  assign rd_data = (wb_en && (wb_reg == rd_idx)) ? wb_data : regs_q[rd_idx];
`else
  assign rd_data = regs_q[rd_idx];
`endif

  shifter u_shifter (
    .din_i  (rd_data),
    .code_i (shift_q),
    .dout_o (rd_shifted)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[wb_reg] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= SH_NONE;
      asel_q  <= 1'b0;
      bsel_q  <= 1'b0;
      imm5_q  <= '0;
      aluop_q <= ALU_ADD;
      ain_q   <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rn_q    <= rn;
            rm_q    <= rm;
            shift_q <= shift;
            asel_q  <= asel;
            bsel_q  <= bsel;
            imm5_q  <= imm5;
            aluop_q <= aluop_in;
            ready_q <= 1'b0;
            state_q <= S_RD_A;
          end
        end
        S_RD_A: begin
          ain_q   <= asel_q ? '0 : rd_data;
          state_q <= S_RD_B;
        end
        S_RD_B: begin
          // The immediate bypasses the shifter entirely.
          bin_q   <= bsel_q ? sx_imm5(imm5_q) : rd_shifted;
          valid_q <= 1'b1;
          state_q <= S_VALID;
        end
        S_VALID: begin
          if (ack) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ain   = ain_q;
  assign bin   = bin_q;
  assign aluop = aluop_q;
  assign valid = valid_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: driver tasks push expected {ain,bin,aluop}
// into a queue and a negedge monitor pops/compares on each rising valid.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  rn = '0, rm = '0;
  logic [1:0]  shift = '0;
  logic        asel = 1'b0, bsel = 1'b0;
  logic [4:0]  imm5 = '0;
  logic [1:0]  aluop_in = '0;
  logic        ack = 1'b0;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_reg = '0;
  logic [15:0] wb_data = '0;
  logic [15:0] ain, bin;
  logic [1:0]  aluop;
  logic        valid, ready;

  int          n_vec = 0;
  int          n_err = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_exp;
  logic        prev_valid = 1'b0;

  operand_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rn       (rn),
    .rm       (rm),
    .shift    (shift),
    .asel     (asel),
    .bsel     (bsel),
    .imm5     (imm5),
    .aluop_in (aluop_in),
    .ack      (ack),
    .wb_en    (wb_en),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .ain      (ain),
    .bin      (bin),
    .aluop    (aluop),
    .valid    (valid),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per transaction, taken on the first valid cycle.
  always @(negedge clk) begin
    if (!reset && valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL monitor_unexpected: got valid with ain=0x%0h bin=0x%0h, expected no transaction",
                 ain, bin);
      end else begin
        mon_exp = exp_q.pop_front();
        check("monitor_operands", {ain, bin, aluop}, mon_exp);
      end
    end
    prev_valid = valid;
  end

  task automatic wb_write(input logic [2:0] r, input logic [15:0] d);
    @(negedge clk);
    wb_en = 1'b1; wb_reg = r; wb_data = d;
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  // Returns at the negedge of the first cycle after acceptance (RD_A).
  task automatic issue(input logic [2:0] rn_v, input logic [2:0] rm_v, input logic [1:0] sh,
                       input logic as, input logic bs, input logic [4:0] im, input logic [1:0] op,
                       input logic [15:0] exp_a, input logic [15:0] exp_b);
    int t = 0;
    @(negedge clk);
    while (!ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("issue_ready", 34'(ready), 34'd1);
    start = 1'b1; rn = rn_v; rm = rm_v; shift = sh;
    asel = as; bsel = bs; imm5 = im; aluop_in = op;
    exp_q.push_back({exp_a, exp_b, op});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int lat0, input string name);
    int lat = lat0;
    while (!valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 34'(lat), 34'd3);
  endtask

  task automatic finish_ack(input string name);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check({name, "_ready_after_ack"}, 34'(ready), 34'd1);
    check({name, "_valid_after_ack"}, 34'(valid), 34'd0);
  endtask

  logic [15:0] sh_exp [4];
  logic [15:0] byp_exp;

  initial begin
    sh_exp[0] = 16'h8001; sh_exp[1] = 16'h0002; sh_exp[2] = 16'h4000; sh_exp[3] = 16'hC000;
`ifdef OPERAND_FETCH_BYPASS_EN
    byp_exp = 16'h1234;
`else
    byp_exp = 16'h0005;
`endif

    repeat (2) @(negedge clk);
    check("reset_valid", 34'(valid), 34'd0);
    check("reset_ready", 34'(ready), 34'd1);
    check("reset_operands", {ain, bin, aluop}, 34'd0);
    reset = 1'b0;

    wb_write(3'd1, 16'h0005);
    wb_write(3'd2, 16'h0003);
    wb_write(3'd3, 16'h8001);

    issue(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 5'd0, 2'b01, 16'h0005, 16'h0003);
    wait_valid(1, "basic");
    finish_ack("basic");

    for (int i = 0; i < 4; i++) begin
      issue(3'd3, 3'd3, 2'(i), 1'b0, 1'b0, 5'd0, 2'(i), 16'h8001, sh_exp[i]);
      wait_valid(1, "shift");
      finish_ack("shift");
    end

    issue(3'd1, 3'd3, 2'b01, 1'b1, 1'b1, 5'b10110, 2'b11, 16'h0000, 16'hFFF6);
    wait_valid(1, "imm");
    finish_ack("imm");

    // Stall in VALID: start pulses and R1 writes must not disturb the held outputs.
    issue(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 5'd0, 2'b10, 16'h0005, 16'h0003);
    wait_valid(1, "hold");
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; rn = 3'(i); rm = 3'd3; shift = 2'b01; aluop_in = 2'b00;
      wb_en = 1'b1; wb_reg = 3'd1; wb_data = 16'h7700 + 16'(i);
      @(negedge clk);
      check("hold_valid", 34'(valid), 34'd1);
      check("hold_ready", 34'(ready), 34'd0);
      check("hold_operands", {ain, bin, aluop}, {16'h0005, 16'h0003, 2'b10});
    end
    start = 1'b0; wb_en = 1'b0;
    finish_ack("hold");

    wb_write(3'd1, 16'h0005);
    issue(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 5'd0, 2'b00, byp_exp, 16'h0003);
    wb_en = 1'b1; wb_reg = 3'd1; wb_data = 16'h1234;
    @(negedge clk);
    wb_en = 1'b0;
    wait_valid(2, "bypass");
    finish_ack("bypass");

    issue(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 5'd0, 2'b01, 16'h1234, 16'h0003);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    // This request is discarded by the reset, so it never reaches the monitor.
    void'(exp_q.pop_back());
    check("midreset_valid", 34'(valid), 34'd0);
    check("midreset_ready", 34'(ready), 34'd1);
    check("midreset_ain", 34'(ain), 34'd0);
    check("midreset_bin", 34'(bin), 34'd0);

    issue(3'd1, 3'd1, 2'b00, 1'b0, 1'b0, 5'd0, 2'b11, 16'h0000, 16'h0000);
    wait_valid(1, "post_reset");
    finish_ack("post_reset");

    repeat (5) @(negedge clk);
    check("queue_drained", 34'(exp_q.size()), 34'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
